// File: rtl/alu_mul_sequencer.sv
// rtl/alu_mul_sequencer.sv - shift-and-add MUL sequencer that borrows the shared execute-stage ALU
// Produces the low word of OpA_i * OpB_i, stopping once the remaining multiplier bits are all zero.
module alu_mul_sequencer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  Start_i,
  input  logic                  Kill_i,
  input  logic [DATA_WIDTH-1:0] OpA_i,
  input  logic [DATA_WIDTH-1:0] OpB_i,
  input  logic [DATA_WIDTH-1:0] AluResult_i,
  output logic [DATA_WIDTH-1:0] AluSrcA_o,
  output logic [DATA_WIDTH-1:0] AluSrcB_o,
  output logic [2:0]            AluControl_o,
  output logic                  Busy_o,
  output logic                  Done_o,
  output logic [DATA_WIDTH-1:0] Result_o
);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SLL = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADD   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [DATA_WIDTH-1:0] alu_src_a_q, alu_src_a_d;
  logic [DATA_WIDTH-1:0] alu_src_b_q, alu_src_b_d;
  logic [2:0]            alu_ctrl_q, alu_ctrl_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (Start_i) begin
          mcand_d  = OpA_i;
          mplier_d = OpB_i;
          acc_d    = '0;
          if (OpB_i == '0) begin
            state_d  = S_DONE;
            result_d = '0;
          end else begin
            state_d = S_ADD;
          end
        end
      end
      S_ADD: begin
        if (mplier_q[0]) acc_d = AluResult_i;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        mcand_d  = AluResult_i;
        mplier_d = mplier_q >> 1;
        if (mplier_d == '0) begin
          state_d  = S_DONE;
          result_d = acc_d;
        end else begin
          state_d = S_ADD;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Kill wins over everything, including a same-cycle Start, but leaves the last result visible.
    if (Kill_i) begin
      state_d  = S_IDLE;
      acc_d    = '0;
      mcand_d  = '0;
      mplier_d = '0;
      result_d = result_q;
    end

    // Outputs are precomputed for the state being entered so they can be registered.
    alu_src_a_d = '0;
    alu_src_b_d = '0;
    alu_ctrl_d  = ALU_ADD;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    case (state_d)
      S_ADD: begin
        alu_src_a_d = acc_d;
        alu_src_b_d = mcand_d;
        busy_d      = 1'b1;
      end
      S_SHIFT: begin
        alu_src_a_d = mcand_d;
        alu_src_b_d = DATA_WIDTH'(1);
        alu_ctrl_d  = ALU_SLL;
        busy_d      = 1'b1;
      end
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      result_q    <= '0;
      alu_src_a_q <= '0;
      alu_src_b_q <= '0;
      alu_ctrl_q  <= ALU_ADD;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      result_q    <= result_d;
      alu_src_a_q <= alu_src_a_d;
      alu_src_b_q <= alu_src_b_d;
      alu_ctrl_q  <= alu_ctrl_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign AluSrcA_o    = alu_src_a_q;
  assign AluSrcB_o    = alu_src_b_q;
  assign AluControl_o = alu_ctrl_q;
  assign Busy_o       = busy_q;
  assign Done_o       = done_q;
  assign Result_o     = result_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb/tb_alu_mul_sequencer.sv - scoreboard bench for alu_mul_sequencer
// Models the shared ALU combinationally and predicts product, latency and ALU usage per request.
module tb_alu_mul_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        Start_i;
  logic        Kill_i;
  logic [31:0] OpA_i;
  logic [31:0] OpB_i;
  logic [31:0] AluResult_i;
  logic [31:0] AluSrcA_o;
  logic [31:0] AluSrcB_o;
  logic [2:0]  AluControl_o;
  logic        Busy_o;
  logic        Done_o;
  logic [31:0] Result_o;

  alu_mul_sequencer #(.DATA_WIDTH(32)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .Start_i      (Start_i),
    .Kill_i       (Kill_i),
    .OpA_i        (OpA_i),
    .OpB_i        (OpB_i),
    .AluResult_i  (AluResult_i),
    .AluSrcA_o    (AluSrcA_o),
    .AluSrcB_o    (AluSrcB_o),
    .AluControl_o (AluControl_o),
    .Busy_o       (Busy_o),
    .Done_o       (Done_o),
    .Result_o     (Result_o)
  );

  always #5 clk_i = ~clk_i;

  // Shared ALU stand-in: ADD or shift-left-logical.
  assign AluResult_i = (AluControl_o == 3'b110) ? (AluSrcA_o << AluSrcB_o[4:0])
                                                : (AluSrcA_o + AluSrcB_o);

  typedef struct {
    logic [31:0] prod;
    int          start;
    int          lat;
    int          k;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] last_res = 32'h0;

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int top_k(input logic [31:0] b);
    int k = 0;
    for (int i = 0; i < 32; i++) if (b[i]) k = i + 1;
    return k;
  endfunction

  function automatic exp_t predict(input logic [31:0] a, input logic [31:0] b, input int st);
    exp_t e;
    logic [31:0] p;
    p       = a * b;
    e.prod  = p;
    e.start = st;
    e.k     = top_k(b);
    e.lat   = 2 * e.k + 1;
    return e;
  endfunction

  // Monitor: checks every Done_o pulse against the head of the scoreboard.
  initial begin
    int  busy_cnt = 0;
    bit  alt_ok   = 1'b1;
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (Done_o) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got Done_o=1 expected no pending op (cycle %0d)", cyc);
        end else begin
          e = sb_q.pop_front();
          check("result", 64'(Result_o), 64'(e.prod));
          check("latency", 64'(cyc - e.start + 1), 64'(e.lat));
          check("busy_cycles", 64'(busy_cnt), 64'(2 * e.k));
          check("alu_ctrl_alternation", 64'(alt_ok), 64'(1));
        end
        busy_cnt = 0;
        alt_ok   = 1'b1;
      end else if (Busy_o) begin
        if (AluControl_o !== ((busy_cnt % 2 == 1) ? 3'b110 : 3'b000)) alt_ok = 1'b0;
        busy_cnt++;
      end else begin
        busy_cnt = 0;
        alt_ok   = 1'b1;
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit expect_done);
    exp_t e;
    Start_i = 1'b1;
    OpA_i   = a;
    OpB_i   = b;
    if (expect_done) begin
      e = predict(a, b, cyc + 1);
      sb_q.push_back(e);
      last_res = e.prod;
    end
    @(negedge clk_i);
    Start_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got %0d pending ops expected 0", sb_q.size());
      sb_q.delete();
    end
    @(negedge clk_i);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(Busy_o), 64'(0));
    check({tag, "_done"}, 64'(Done_o), 64'(0));
    check({tag, "_result"}, 64'(Result_o), 64'(0));
    check({tag, "_src_a"}, 64'(AluSrcA_o), 64'(0));
    check({tag, "_src_b"}, 64'(AluSrcB_o), 64'(0));
    check({tag, "_ctrl"}, 64'(AluControl_o), 64'(0));
  endtask

  initial begin
    int st;
    logic [31:0] ra, rb;
    rst_i   = 1'b1;
    Start_i = 1'b0;
    Kill_i  = 1'b0;
    OpA_i   = '0;
    OpB_i   = '0;
    repeat (2) @(negedge clk_i);
    check_all_zero("reset");
    rst_i = 1'b0;
    @(negedge clk_i);

    issue(32'd6, 32'd7, 1'b1);
    wait_idle();
    issue(32'h1234, 32'd0, 1'b1);
    wait_idle();
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_idle();
    issue(32'h8000_0000, 32'd2, 1'b1);
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = (i % 10 == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      issue(ra, rb, 1'b1);
      wait_idle();
    end

    // Start held high while busy: the second request is taken only after DONE.
    Start_i = 1'b1;
    OpA_i   = 32'd3;
    OpB_i   = 32'd3;
    st      = cyc + 1;
    sb_q.push_back(predict(32'd3, 32'd3, st));
    sb_q.push_back(predict(32'd2, 32'd2, st + 6));
    last_res = 32'd4;
    @(negedge clk_i);
    OpA_i = 32'd2;
    OpB_i = 32'd2;
    while (cyc < st + 6) @(negedge clk_i);
    Start_i = 1'b0;
    wait_idle();

    // Kill sampled on the fourth edge of a long multiply.
    issue(32'd5, 32'h100, 1'b0);
    repeat (2) @(negedge clk_i);
    Kill_i = 1'b1;
    @(negedge clk_i);
    Kill_i = 1'b0;
    check("kill_busy", 64'(Busy_o), 64'(0));
    check("kill_done", 64'(Done_o), 64'(0));
    check("kill_result_hold", 64'(Result_o), 64'(last_res));
    issue(32'd3, 32'd3, 1'b1);
    wait_idle();

    // Asynchronous reset in the middle of a SHIFT cycle.
    issue(32'hFF, 32'hFF, 1'b0);
    st = cyc;
    while (cyc < st + 3) @(negedge clk_i);
    check("pre_reset_busy", 64'(Busy_o), 64'(1));
    #1 rst_i = 1'b1;
    #1 check_all_zero("async_reset");
    sb_q.delete();
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    issue(32'd4, 32'd4, 1'b1);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before 500000ns");
    $fatal(1);
  end

endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
- Multi-cycle controller that performs 32-bit MUL (low 32 bits of product) by sequencing the shared ALU through shift-and-add iterations.
- Sits beside the ALU in the execute stage.
- While Busy_o is high, the core's ALU-operand mux selects this block's AluSrcA_o, AluSrcB_o and AluControl_o. The ALU result returns on AluResult_i.
- Early termination on the multiplier's highest set bit keeps small operands fast.

Parameters:
- DATA_WIDTH, 32, operand/result width; only 32 is supported (shift amount uses 5 bits).

Ports:
- clk_i  input  1  clock; single clock domain.
- rst_i  input  1  asynchronous, active-high reset.
- Start_i  input  1  request; sampled only in IDLE.
- Kill_i  input  1  flush; aborts any operation.
- OpA_i  input  DATA_WIDTH  multiplicand.
- OpB_i  input  DATA_WIDTH  multiplier.
- AluResult_i  input  DATA_WIDTH  combinational result from the shared ALU.
- AluSrcA_o  output  DATA_WIDTH  ALU operand A.
- AluSrcB_o  output  DATA_WIDTH  ALU operand B.
- AluControl_o  output  3  ALU op: 000 = ADD, 110 = SLL.
- Busy_o  output  1  sequencer owns the ALU (ADD or SHIFT state).
- Done_o  output  1  one-cycle completion pulse.
- Result_o  output  DATA_WIDTH  product low word, registered.

Behaviour:
- Interface decision: one clock (clk_i); rst_i is asynchronous and active-high.
- Reset (async, at any time, including mid-operation) forces:
  - state = IDLE
  - Acc, Mcand, Mplier = 0
  - Result_o = 0, Busy_o = 0, Done_o = 0
  - AluSrcA_o = 0, AluSrcB_o = 0, AluControl_o = 000
- FSM states: IDLE, ADD, SHIFT, DONE. Outputs are decoded from state and registers only; there is no combinational path from Start_i to the outputs.
- IDLE:
  - ALU outputs are all zero and AluControl_o = 000.
  - On an edge with Start_i = 1 and Kill_i = 0: Mcand <= OpA_i, Mplier <= OpB_i, Acc <= 0.
  - Next state is DONE if OpB_i == 0, otherwise ADD.
- ADD:
  - AluSrcA_o = Acc, AluSrcB_o = Mcand, AluControl_o = 000.
  - At the edge: if Mplier[0] = 1 then Acc <= AluResult_i, else Acc is held.
  - Next state: SHIFT.
- SHIFT:
  - AluSrcA_o = Mcand, AluSrcB_o = 1, AluControl_o = 110.
  - At the edge: Mcand <= AluResult_i and Mplier <= Mplier >> 1 (logical).
  - Next state: DONE if (Mplier >> 1) == 0, otherwise ADD.
- DONE:
  - Done_o = 1 and Result_o <= Acc (loaded on the edge entering DONE).
  - ALU outputs are zero.
  - Next state: IDLE unconditionally. Start_i in this cycle is ignored.
- Result_o holds its value until the next completed operation. Kill and reset do not alter it, except that reset clears it.
- Busy_o = 1 in ADD or SHIFT only.
- Latency:
  - k = 1 + index of the highest set bit of OpB_i.
  - Done_o is asserted 2k+1 cycles after the edge that samples Start_i.
  - OpB_i == 0 gives 1 cycle. Maximum is 65 cycles (bit 31 set).
- Arithmetic:
  - All additions and shifts wrap modulo 2^32.
  - The result equals (OpA_i * OpB_i) mod 2^32, which is correct for both signed and unsigned operands.
  - Mcand bits shifted past bit 31 are discarded.
- Start_i while not in IDLE is ignored, with no queuing. The requester must hold Start_i until it observes Busy_o or Done_o.
- Kill_i = 1 at any edge forces state to IDLE:
  - No Done_o pulse is produced.
  - Acc, Mcand and Mplier are cleared.
  - Kill_i has priority over Start_i in the same cycle.
- The block's correctness relies on the ALU being combinational, i.e. AluResult_i is valid in the same cycle as the operands.

Test Plan:
- OpA = 6, OpB = 7 (k = 3), Start pulse:
  - Busy_o high for 6 cycles.
  - AluControl_o alternates 000/110.
  - Done_o one cycle at start+7 with Result_o = 42.
- OpA = 0x1234, OpB = 0:
  - No ALU activity and Busy_o stays low.
  - Done_o at start+1 with Result_o = 0.
- OpA = 0xFFFFFFFF, OpB = 0xFFFFFFFF:
  - Done_o at start+65 with Result_o = 0x00000001.
  - A second case, OpA = 0x80000000, OpB = 2, gives Result_o = 0 (wrap).
- Start OpA = 5, OpB = 0x100; assert Kill_i in cycle 4:
  - Next cycle is IDLE and Busy_o = 0.
  - No Done_o is produced and Result_o keeps its previous value.
  - An immediate new Start with 3 × 3 gives Result_o = 9 at start+5.
- Start 3 × 3; hold Start_i high with OpA = 2, OpB = 2 while busy:
  - First Done_o reports 9.
  - The held request is accepted in IDLE after DONE, giving a second Done_o with Result_o = 4.
- Start 0xFF × 0xFF; assert rst_i asynchronously mid-SHIFT:
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - After release, 4 × 4 gives Result_o = 16 at start+7.
